// File: rtl/memory_layer_winner_search_if.sv
// Bundles the control/result handshake and the distance-memory read port of the
// winner search. The slave side is the search engine; the master side is whoever
// issues start and serves the distance/validity memory.
interface memory_layer_winner_search_if #(
    parameter int DIST_W = 16
);
    logic              start;
    logic [31:0]       class_i;
    logic [DIST_W-1:0] sim_th;
    logic [31:0]       rd_node;
    logic [31:0]       rd_class;
    logic [DIST_W-1:0] rd_dist;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic [31:0]       node1;
    logic [31:0]       node2;
    logic [31:0]       class_o;
    logic [DIST_W-1:0] win_dist;
    logic              en_connection;
    logic              new_node;

    modport master (
        output start, class_i, sim_th, rd_dist, rd_valid,
        input  rd_node, rd_class, busy, done, node1, node2, class_o, win_dist,
               en_connection, new_node
    );

    modport slave (
        input  start, class_i, sim_th, rd_dist, rd_valid,
        output rd_node, rd_class, busy, done, node1, node2, class_o, win_dist,
               en_connection, new_node
    );
endinterface

// File: rtl/memory_layer_winner_search.sv
// Memory-layer winner search: scans nodes 1..NODE_COUNT-1 of one class, keeps the
// nearest and second-nearest valid node, then either requests a connection between
// them or requests insertion of a new node.
//
// state  | meaning
// IDLE   | waiting for start; result outputs hold the last search
// SCAN   | presenting rd_node 1..NODE_COUNT-1, evaluating data for rd_node-1
// DRAIN  | evaluating the data returned for the last node
// RESULT | result outputs valid, done and decision pulses high for this cycle
module memory_layer_winner_search #(
    parameter int NODE_COUNT  = 8,
    parameter int CLASS_COUNT = 4,
    parameter int DIST_W      = 16
) (
    input logic                         clk,
    input logic                         rst_n,
    memory_layer_winner_search_if.slave bus
);
    localparam logic [31:0] LAST_NODE = 32'(NODE_COUNT - 1);
    localparam logic [31:0] IDX_NONE  = '1;

    if (NODE_COUNT < 3 || CLASS_COUNT < 2) begin : g_param_check
        $error("memory_layer_winner_search: NODE_COUNT must be >= 3 and CLASS_COUNT >= 2");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESULT} state_t;

    state_t            state_q, state_d;
    logic [31:0]       rd_node_q;
    logic [31:0]       class_q;
    logic [DIST_W-1:0] sim_th_q;
    logic [DIST_W-1:0] best1_q, best1_d, best2_q, best2_d;
    logic [31:0]       idx1_q, idx1_d, idx2_q, idx2_d;
    logic [31:0]       node1_q, node2_q, class_o_q;
    logic [DIST_W-1:0] win_dist_q;
    logic              eval_en;
    logic [31:0]       eval_node;
    logic              no_match;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SCAN;
            SCAN:    if (rd_node_q == LAST_NODE) state_d = DRAIN;
            DRAIN:   state_d = RESULT;
            RESULT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: status, done and the mutually exclusive decision pulses.
    always_comb begin
        bus.busy          = (state_q != IDLE);
        bus.done          = (state_q == RESULT);
        no_match          = (node1_q == IDX_NONE) || (win_dist_q > sim_th_q);
        bus.new_node      = (state_q == RESULT) && no_match;
        bus.en_connection = (state_q == RESULT) && !no_match
                            && !node2_q[31] && (node2_q != 32'd0);
    end

    // Evaluate the returned distance against the running best two (strict compare,
    // so on equal distances the earlier, lower-index node keeps its place).
    always_comb begin
        eval_en   = 1'b0;
        eval_node = '0;
        best1_d   = best1_q;
        best2_d   = best2_q;
        idx1_d    = idx1_q;
        idx2_d    = idx2_q;
        if (state_q == SCAN && rd_node_q != 32'd1) begin
            eval_en   = 1'b1;
            eval_node = rd_node_q - 32'd1;
        end else if (state_q == DRAIN) begin
            eval_en   = 1'b1;
            eval_node = LAST_NODE;
        end
        if (eval_en && bus.rd_valid) begin
            if (bus.rd_dist < best1_q) begin
                best2_d = best1_q;
                idx2_d  = idx1_q;
                best1_d = bus.rd_dist;
                idx1_d  = eval_node;
            end else if (bus.rd_dist < best2_q) begin
                best2_d = bus.rd_dist;
                idx2_d  = eval_node;
            end
        end
    end

    // Datapath: latch request, walk the read address, track best two, publish result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_node_q  <= '0;
            class_q    <= '0;
            sim_th_q   <= '0;
            best1_q    <= '1;
            best2_q    <= '1;
            idx1_q     <= IDX_NONE;
            idx2_q     <= IDX_NONE;
            node1_q    <= IDX_NONE;
            node2_q    <= IDX_NONE;
            class_o_q  <= '0;
            win_dist_q <= '1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        class_q   <= bus.class_i;
                        sim_th_q  <= bus.sim_th;
                        best1_q   <= '1;
                        best2_q   <= '1;
                        idx1_q    <= IDX_NONE;
                        idx2_q    <= IDX_NONE;
                        rd_node_q <= 32'd1;
                    end
                end
                SCAN: begin
                    best1_q   <= best1_d;
                    best2_q   <= best2_d;
                    idx1_q    <= idx1_d;
                    idx2_q    <= idx2_d;
                    rd_node_q <= (rd_node_q == LAST_NODE) ? 32'd0 : rd_node_q + 32'd1;
                end
                DRAIN: begin
                    best1_q    <= best1_d;
                    best2_q    <= best2_d;
                    idx1_q     <= idx1_d;
                    idx2_q     <= idx2_d;
                    node1_q    <= idx1_d;
                    node2_q    <= idx2_d;
                    win_dist_q <= best1_d;
                    class_o_q  <= class_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rd_node  = rd_node_q;
    assign bus.rd_class = class_q;
    assign bus.node1    = node1_q;
    assign bus.node2    = node2_q;
    assign bus.class_o  = class_o_q;
    assign bus.win_dist = win_dist_q;
endmodule

// File: tb/tb_memory_layer_winner_search.sv
module tb_memory_layer_winner_search;
    localparam int NODE_COUNT = 8;
    localparam int DIST_W     = 16;

    typedef struct {
        int          n1;
        int          n2;
        int          cls;
        logic [15:0] wd;
        logic        en;
        logic        nn;
        int          due;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          edges  = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [15:0] dmem[NODE_COUNT];
    logic        vmem[NODE_COUNT];

    memory_layer_winner_search_if #(.DIST_W(DIST_W)) bus();

    memory_layer_winner_search #(
        .NODE_COUNT (NODE_COUNT),
        .CLASS_COUNT(4),
        .DIST_W     (DIST_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    // Distance/validity memory: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_node < 32'(NODE_COUNT)) begin
            bus.rd_dist  <= dmem[bus.rd_node[2:0]];
            bus.rd_valid <= vmem[bus.rd_node[2:0]];
        end else begin
            bus.rd_dist  <= '1;
            bus.rd_valid <= 1'b0;
        end
    end

    // Reference: winner = smallest (distance, index); runner-up = smallest of the rest.
    function automatic exp_t model(input int cls, input logic [15:0] th);
        exp_t e;
        int   b1 = -1;
        int   b2 = -1;
        for (int n = 1; n < NODE_COUNT; n++)
            if (vmem[n] && dmem[n] != 16'hFFFF && (b1 < 0 || dmem[n] < dmem[b1])) b1 = n;
        for (int n = 1; n < NODE_COUNT; n++)
            if (n != b1 && vmem[n] && dmem[n] != 16'hFFFF && (b2 < 0 || dmem[n] < dmem[b2])) b2 = n;
        e.n1  = b1;
        e.n2  = b2;
        e.cls = cls;
        e.wd  = (b1 < 0) ? 16'hFFFF : dmem[b1];
        e.nn  = (b1 < 0) || (e.wd > th);
        e.en  = !e.nn && (b2 > 0);
        e.due = 0;
        return e;
    endfunction

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            checks++;
            if (bus.done !== 1'b1 && (bus.en_connection !== 1'b0 || bus.new_node !== 1'b0)) begin
                errors++;
                $display("FAIL stray_pulse: en=%0b new=%0b without done, required 0/0",
                         bus.en_connection, bus.new_node);
            end
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", edges);
                end else begin
                    e = sb.pop_front();
                    checks += 7;
                    if (edges != e.due) begin errors++;
                        $display("FAIL done_cycle: got %0d, required %0d", edges, e.due); end
                    if (bus.node1 !== 32'(e.n1)) begin errors++;
                        $display("FAIL node1: got %0d, required %0d", $signed(bus.node1), e.n1); end
                    if (bus.node2 !== 32'(e.n2)) begin errors++;
                        $display("FAIL node2: got %0d, required %0d", $signed(bus.node2), e.n2); end
                    if (bus.class_o !== 32'(e.cls)) begin errors++;
                        $display("FAIL class_o: got %0d, required %0d", bus.class_o, e.cls); end
                    if (bus.win_dist !== e.wd) begin errors++;
                        $display("FAIL win_dist: got %0d, required %0d", bus.win_dist, e.wd); end
                    if (bus.en_connection !== e.en) begin errors++;
                        $display("FAIL en_connection: got %0b, required %0b", bus.en_connection, e.en); end
                    if (bus.new_node !== e.nn) begin errors++;
                        $display("FAIL new_node: got %0b, required %0b", bus.new_node, e.nn); end
                end
            end
        end
    end

    task automatic run_scan(input int cls, input logic [15:0] th);
        exp_t e;
        @(negedge clk);
        bus.class_i = 32'(cls);
        bus.sim_th  = th;
        bus.start   = 1'b1;
        e     = model(cls, th);
        e.due = edges + 9;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scan_timeout: %0d results pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic load_spec_pattern();
        dmem[0] = 16'd0;  vmem[0] = 1'b0;
        dmem[1] = 16'd50; dmem[2] = 16'd20; dmem[3] = 16'd90; dmem[4] = 16'd20;
        dmem[5] = 16'd70; dmem[6] = 16'd10; dmem[7] = 16'd99;
        for (int n = 1; n < NODE_COUNT; n++) vmem[n] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 10;
        if (bus.rd_node !== 32'd0) begin errors++; $display("FAIL rst_rd_node: got %0d, required 0", bus.rd_node); end
        if (bus.rd_class !== 32'd0) begin errors++; $display("FAIL rst_rd_class: got %0d, required 0", bus.rd_class); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b, required 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b, required 0", bus.done); end
        if (bus.en_connection !== 1'b0) begin errors++; $display("FAIL rst_en: got %0b, required 0", bus.en_connection); end
        if (bus.new_node !== 1'b0) begin errors++; $display("FAIL rst_new: got %0b, required 0", bus.new_node); end
        if (bus.node1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_node1: got %0h, required ffffffff", bus.node1); end
        if (bus.node2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_node2: got %0h, required ffffffff", bus.node2); end
        if (bus.class_o !== 32'd0) begin errors++; $display("FAIL rst_class_o: got %0d, required 0", bus.class_o); end
        if (bus.win_dist !== 16'hFFFF) begin errors++; $display("FAIL rst_win_dist: got %0h, required ffff", bus.win_dist); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_connect();
        exp_t e;
        int   start_edge;
        load_spec_pattern();
        @(negedge clk);
        bus.class_i = 32'd2;
        bus.sim_th  = 16'd30;
        bus.start   = 1'b1;
        start_edge  = edges;
        e     = model(2, 16'd30);
        e.due = start_edge + 9;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        checks += 2;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL conn_busy: got %0b, required 1", bus.busy); end
        if (bus.rd_node !== 32'd1) begin errors++; $display("FAIL conn_rd_node1: got %0d, required 1", bus.rd_node); end
        @(negedge clk);
        checks += 2;
        if (bus.rd_node !== 32'd2) begin errors++; $display("FAIL conn_rd_node2: got %0d, required 2", bus.rd_node); end
        if (bus.rd_class !== 32'd2) begin errors++; $display("FAIL conn_rd_class: got %0d, required 2", bus.rd_class); end
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        checks += 4;
        if (sb.size() != 0) begin errors++; $display("FAIL conn_timeout: %0d pending, required 0", sb.size()); sb.delete(); end
        if (bus.node1 !== 32'd6) begin errors++; $display("FAIL conn_node1: got %0d, required 6", bus.node1); end
        if (bus.node2 !== 32'd2) begin errors++; $display("FAIL conn_node2: got %0d, required 2", bus.node2); end
        if (bus.win_dist !== 16'd10) begin errors++; $display("FAIL conn_win_dist: got %0d, required 10", bus.win_dist); end
    endtask

    task automatic test_new_node();
        load_spec_pattern();
        run_scan(2, 16'd5);
        checks += 2;
        if (bus.node1 !== 32'd6) begin errors++; $display("FAIL newn_node1: got %0d, required 6", bus.node1); end
        if (bus.node2 !== 32'd2) begin errors++; $display("FAIL newn_node2: got %0d, required 2", bus.node2); end
    endtask

    task automatic test_single();
        for (int n = 0; n < NODE_COUNT; n++) begin dmem[n] = 16'd7; vmem[n] = 1'b0; end
        dmem[3] = 16'd4;
        vmem[3] = 1'b1;
        run_scan(1, 16'd30);
        checks += 2;
        if (bus.node1 !== 32'd3) begin errors++; $display("FAIL single_node1: got %0d, required 3", bus.node1); end
        if (bus.node2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL single_node2: got %0h, required ffffffff", bus.node2); end
    endtask

    task automatic test_none();
        for (int n = 0; n < NODE_COUNT; n++) begin dmem[n] = 16'(n); vmem[n] = 1'b0; end
        run_scan(3, 16'd100);
        checks += 2;
        if (bus.node1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL none_node1: got %0h, required ffffffff", bus.node1); end
        if (bus.win_dist !== 16'hFFFF) begin errors++; $display("FAIL none_win_dist: got %0h, required ffff", bus.win_dist); end
    endtask

    task automatic test_reset_mid_scan();
        int start_edge;
        int dones = 0;
        load_spec_pattern();
        run_scan(2, 16'd30);
        @(negedge clk);
        bus.class_i = 32'd3;
        bus.sim_th  = 16'd30;
        bus.start   = 1'b1;
        start_edge  = edges;
        @(negedge clk);
        bus.start = 1'b0;
        while (edges < start_edge + 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks += 7;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b, required 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_done: got %0b, required 0", bus.done); end
        if (bus.rd_node !== 32'd0) begin errors++; $display("FAIL mid_rd_node: got %0d, required 0", bus.rd_node); end
        if (bus.rd_class !== 32'd0) begin errors++; $display("FAIL mid_rd_class: got %0d, required 0", bus.rd_class); end
        if (bus.node1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_node1: got %0h, required ffffffff", bus.node1); end
        if (bus.class_o !== 32'd0) begin errors++; $display("FAIL mid_class_o: got %0d, required 0", bus.class_o); end
        if (bus.win_dist !== 16'hFFFF) begin errors++; $display("FAIL mid_win_dist: got %0h, required ffff", bus.win_dist); end
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses, required 0", dones); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   start_edge;
        logic exp_busy;
        load_spec_pattern();
        @(negedge clk);
        bus.class_i = 32'd2;
        bus.sim_th  = 16'd30;
        bus.start   = 1'b1;
        start_edge  = edges;
        e     = model(2, 16'd30);
        e.due = start_edge + 9;
        sb.push_back(e);
        e.due = start_edge + 19;
        sb.push_back(e);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_busy = !(k == 10 || k == 20);
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL b2b_busy: cycle %0d got %0b, required %0b", k, bus.busy, exp_busy);
            end
        end
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending: %0d results pending, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int n = 0; n < NODE_COUNT; n++) begin
                dmem[n] = 16'($urandom_range(0, 12));
                vmem[n] = ($urandom_range(0, 3) != 0);
            end
            if (it == 5) dmem[1] = 16'hFFFF;
            run_scan(int'($urandom_range(1, 3)), 16'($urandom_range(0, 12)));
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.class_i = '0;
        bus.sim_th  = '0;
        for (int n = 0; n < NODE_COUNT; n++) begin dmem[n] = '0; vmem[n] = 1'b0; end
        test_reset();
        test_connect();
        test_new_node();
        test_single();
        test_none();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
